// File: rtl/ordered_bypass_merge_service.sv
// ordered_bypass_merge_service: steers packets to a client or a bypass buffer and re-merges them in arrival order
module obms_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(D);
  localparam logic [AW:0] L_FULL = (AW+1)'(D);
  logic [W-1:0] r_mem [D];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  // storage array carries no reset; validity comes from the pointers
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_din;
  // pointers and occupancy; a same-cycle pop never sees the word being written
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  assign o_head  = r_mem[r_rd];
  assign o_full  = r_cnt == L_FULL;
  assign o_empty = r_cnt == '0;
endmodule

module ordered_bypass_merge_service #(
  parameter int DATA_W       = 512,
  parameter int EMPTY_W      = 6,
  parameter int META_W       = 128,
  parameter int BYPASS_BIT   = 0,
  parameter int BYP_DEPTH    = 512,
  parameter int ORDER_DEPTH  = 64,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_sop,
  input  logic                              in_eop,
  input  logic [EMPTY_W-1:0]                in_empty,
  input  logic [META_W-1:0]                 in_meta,
  output logic                              proc_valid,
  input  logic                              proc_ready,
  output logic [DATA_W-1:0]                 proc_data,
  output logic                              proc_sop,
  output logic                              proc_eop,
  output logic [EMPTY_W-1:0]                proc_empty,
  output logic [META_W-1:0]                 proc_meta,
  input  logic                              ret_valid,
  output logic                              ret_ready,
  input  logic [DATA_W-1:0]                 ret_data,
  input  logic                              ret_sop,
  input  logic                              ret_eop,
  input  logic [EMPTY_W-1:0]                ret_empty,
  input  logic [META_W-1:0]                 ret_meta,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [EMPTY_W-1:0]                out_empty,
  output logic [META_W-1:0]                 out_meta,
  output logic [31:0]                       stats_byp_pkt,
  output logic [31:0]                       stats_proc_pkt,
  output logic [31:0]                       stats_out_pkt,
  output logic [31:0]                       byp_fill_level,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);
  localparam int IW = $clog2(MAX_INFLIGHT+1);
  localparam int FW = DATA_W + EMPTY_W + 2;
  typedef enum logic [1:0] {IDLE, SEND_BYP, SEND_PROC} state_t;
  state_t r_state;
  logic r_run, r_mid, r_path;
  logic [IW-1:0] r_inflight;
  logic [31:0] r_byp_pkt, r_proc_pkt, r_out_pkt, r_byp_fill;
  logic w_path, w_sop_ok, w_in_fire, w_in_sop, w_byp_push, w_byp_pop;
  logic w_out_fire, w_out_eop, w_ret_eop;
  logic w_ord_full, w_ord_empty, w_ord_head, w_ord_pop;
  logic w_bm_full, w_bm_empty, w_bm_pop;
  logic w_byp_full, w_byp_empty;
  logic [META_W-1:0] w_bm_head;
  logic [FW-1:0] w_byp_head;
  // the path of a packet comes from its SOP meta and is held until its EOP
  assign w_path = r_mid ? r_path : in_meta[BYPASS_BIT];
  // packet-start admission: order slot plus meta slot or client in-flight budget
  assign w_sop_ok = r_mid || (!w_ord_full && (w_path ? !w_bm_full : r_inflight < IW'(MAX_INFLIGHT)));
  assign in_ready   = r_run && w_sop_ok && (w_path ? !w_byp_full : proc_ready);
  assign proc_valid = r_run && in_valid && !w_path && w_sop_ok;
  assign proc_data  = in_data;
  assign proc_sop   = in_sop;
  assign proc_eop   = in_eop;
  assign proc_empty = in_empty;
  assign proc_meta  = in_meta;
  assign w_in_fire  = in_valid && in_ready;
  assign w_in_sop   = w_in_fire && !r_mid;
  assign w_byp_push = w_in_fire && w_path;
  assign w_out_fire = out_valid && out_ready;
  assign w_out_eop  = w_out_fire && out_eop;
  assign w_ret_eop  = ret_valid && ret_ready && ret_eop;
  assign w_ord_pop  = r_state == IDLE && !w_ord_empty;
  assign w_byp_pop  = r_state == SEND_BYP && w_out_fire;
  assign w_bm_pop   = r_state == SEND_BYP && w_out_eop;
  assign out_valid  = r_state == SEND_BYP ? !w_byp_empty : r_state == SEND_PROC && ret_valid;
  assign ret_ready  = r_state == SEND_PROC && out_ready;
  assign {out_data, out_sop, out_eop, out_empty} = r_state == SEND_PROC ? {ret_data, ret_sop, ret_eop, ret_empty} : w_byp_head;
  assign out_meta       = r_state == SEND_PROC ? ret_meta : w_bm_head;
  assign stats_byp_pkt  = r_byp_pkt;
  assign stats_proc_pkt = r_proc_pkt;
  assign stats_out_pkt  = r_out_pkt;
  assign byp_fill_level = r_byp_fill;
  assign inflight       = r_inflight;
  obms_fifo #(.W(1), .D(ORDER_DEPTH)) u_order (
    .clk(clk), .rst_n(rst_n), .i_push(w_in_sop), .i_pop(w_ord_pop), .i_din(w_path),
    .o_head(w_ord_head), .o_full(w_ord_full), .o_empty(w_ord_empty)
  );
  obms_fifo #(.W(META_W), .D(ORDER_DEPTH)) u_byp_meta (
    .clk(clk), .rst_n(rst_n), .i_push(w_in_sop && w_path), .i_pop(w_bm_pop), .i_din(in_meta),
    .o_head(w_bm_head), .o_full(w_bm_full), .o_empty(w_bm_empty)
  );
  obms_fifo #(.W(FW), .D(BYP_DEPTH)) u_byp (
    .clk(clk), .rst_n(rst_n), .i_push(w_byp_push), .i_pop(w_byp_pop),
    .i_din({in_data, in_sop, in_eop, in_empty}),
    .o_head(w_byp_head), .o_full(w_byp_full), .o_empty(w_byp_empty)
  );
  // input packet tracking; r_run keeps the input side closed while in reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_mid  <= 1'b0;
      r_path <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire) begin
        r_mid  <= !in_eop;
        r_path <= w_path;
      end
    end
  // client occupancy, bypass fill level and wrapping packet statistics
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_inflight <= '0;
      r_byp_fill <= '0;
      r_byp_pkt  <= '0;
      r_proc_pkt <= '0;
      r_out_pkt  <= '0;
    end else begin
      r_inflight <= r_inflight + IW'(w_in_sop && !w_path) - IW'(w_ret_eop);
      r_byp_fill <= r_byp_fill + 32'(w_byp_push) - 32'(w_byp_pop);
      if (w_in_sop && w_path) r_byp_pkt <= r_byp_pkt + 1'b1;
      if (w_in_sop && !w_path) r_proc_pkt <= r_proc_pkt + 1'b1;
      if (w_out_eop) r_out_pkt <= r_out_pkt + 1'b1;
    end
  // output sequencer: take the next path from the order FIFO, forward one whole packet, then idle a cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= r_state == IDLE ? (w_ord_empty ? IDLE : w_ord_head ? SEND_BYP : SEND_PROC)
                                    : w_out_eop ? IDLE : r_state;
endmodule

// File: tb/tb_ordered_bypass_merge_service.sv
// tb_ordered_bypass_merge_service: randomized scoreboard bench for the ordered bypass merge service
module tb_ordered_bypass_merge_service;
  localparam int DW = 32, EW = 2, MW = 8, MAXI = 2, BD = 8;
  localparam logic [DW-1:0] K = 32'hA5A5_0000;
  typedef struct packed {logic [DW-1:0] d; logic s; logic e; logic [EW-1:0] em; logic [MW-1:0] m;} flit_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_sop = 0, in_eop = 0;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_empty = '0;
  logic [MW-1:0] in_meta = '0;
  logic proc_valid, proc_ready = 1, proc_sop, proc_eop;
  logic [DW-1:0] proc_data;
  logic [EW-1:0] proc_empty;
  logic [MW-1:0] proc_meta;
  logic ret_valid = 0, ret_ready, ret_sop = 0, ret_eop = 0;
  logic [DW-1:0] ret_data = '0;
  logic [EW-1:0] ret_empty = '0;
  logic [MW-1:0] ret_meta = '0;
  logic out_valid, out_ready = 0, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;
  logic [MW-1:0] out_meta;
  logic [31:0] stats_byp_pkt, stats_proc_pkt, stats_out_pkt, byp_fill_level;
  logic [1:0] inflight;
  int checks = 0, errors = 0;
  flit_t exp_q[$], cli_q[$];
  bit exp_b[$];
  int cli_t[$];
  int cyc = 0, in_fires = 0, out_fires = 0, ret_credits = 1000, cli_delay = 0, out_mode = 0;
  int first_in = -1, first_out = -1, m_byp = 0, m_proc = 0, m_infl = 0, m_fill = 0;
  bit abort = 0;

  ordered_bypass_merge_service #(.DATA_W(DW), .EMPTY_W(EW), .META_W(MW), .BYPASS_BIT(0),
    .BYP_DEPTH(BD), .ORDER_DEPTH(8), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_meta(in_meta),
    .proc_valid(proc_valid), .proc_ready(proc_ready), .proc_data(proc_data), .proc_sop(proc_sop),
    .proc_eop(proc_eop), .proc_empty(proc_empty), .proc_meta(proc_meta),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data), .ret_sop(ret_sop),
    .ret_eop(ret_eop), .ret_empty(ret_empty), .ret_meta(ret_meta),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty), .out_meta(out_meta),
    .stats_byp_pkt(stats_byp_pkt), .stats_proc_pkt(stats_proc_pkt), .stats_out_pkt(stats_out_pkt),
    .byp_fill_level(byp_fill_level), .inflight(inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // output back-pressure pattern and the client's in-order return side
  initial forever begin
    @(posedge clk); #1;
    out_ready = out_mode == 0 ? 1'b1 : out_mode == 1 ? 1'b0 : out_mode == 2 ? !out_ready : 1'($urandom);
    ret_valid = cli_q.size() > 0 && ret_credits > 0 && cyc >= cli_t[0] + cli_delay;
    if (cli_q.size() > 0) {ret_data, ret_sop, ret_eop, ret_empty, ret_meta} = cli_q[0];
  end

  // transfer monitor: client capture, scoreboard compare, occupancy model
  always @(negedge clk) if (rst_n) begin
    check("inflight", inflight, m_infl);
    check("fill", byp_fill_level, m_fill);
    check("inflight_cap", 64'(inflight <= 2'(MAXI)), 1);
    if (in_valid && in_ready) begin
      in_fires++;
      if (in_sop && first_in < 0) first_in = cyc;
      if (in_meta[0]) m_fill++;
      else if (in_sop) m_infl++;
    end
    if (proc_valid && proc_ready) begin
      cli_q.push_back({proc_data ^ K, proc_sop, proc_eop, proc_empty, proc_meta});
      cli_t.push_back(cyc);
    end
    if (ret_valid && ret_ready) begin
      void'(cli_q.pop_front());
      void'(cli_t.pop_front());
      if (ret_eop) begin m_infl--; ret_credits--; end
    end
    if (out_valid && out_ready) begin
      out_fires++;
      if (out_sop && first_out < 0) first_out = cyc;
      check("out_pending", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        if (exp_b.pop_front()) m_fill--;
        check("out_flit", {out_data, out_sop, out_eop, out_empty, out_meta}, exp_q.pop_front());
      end
    end
  end

  task automatic send_pkt(input int n, input bit byp);
    logic [MW-1:0] m;
    flit_t f;
    bit acc;
    m = {7'($urandom), byp};
    for (int i = 0; i < n && !abort; i++) begin
      f = {DW'($urandom), i == 0, i == n - 1, EW'($urandom), m};
      {in_data, in_sop, in_eop, in_empty, in_meta} = f;
      in_valid = 1;
      acc = 0;
      for (int t = 0; t < 2000 && !acc && !abort; t++) begin
        @(negedge clk);
        acc = in_valid && in_ready && rst_n;
      end
      if (abort) break;
      check("in_accept", acc, 1);
      if (!acc) break;
      if (!byp) f.d = f.d ^ K;
      exp_q.push_back(f);
      exp_b.push_back(byp);
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!abort) begin
      if (byp) m_byp++;
      else m_proc++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && (exp_q.size() > 0 || in_valid); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    check("stats_byp", stats_byp_pkt, m_byp);
    check("stats_proc", stats_proc_pkt, m_proc);
    check("stats_out", stats_out_pkt, m_byp + m_proc);
  endtask

  initial begin
    int base, of0;
    in_valid = 1; in_sop = 1; in_meta = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_proc_valid", proc_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ret_ready", ret_ready, 0);
    check("rst_stats", {stats_byp_pkt, stats_out_pkt}, 0);
    in_valid = 0;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ret_ready", ret_ready, 0);
    // bypass only, latency 2
    send_pkt(1, 1); send_pkt(4, 1); send_pkt(2, 1);
    drain();
    check("byp_latency", first_out - first_in, 2);
    // proc head blocks a later bypass packet until its return
    cli_delay = 20;
    of0 = out_fires;
    send_pkt(2, 0); send_pkt(1, 1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("hol_out_valid", out_valid, 0);
    check("hol_fires", out_fires - of0, 0);
    drain();
    cli_delay = 0;
    // in-flight cap
    ret_credits = 0;
    send_pkt(1, 0); send_pkt(2, 0);
    fork send_pkt(1, 0); join_none
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("cap_in_ready", in_ready, 0);
    check("cap_proc_valid", proc_valid, 0);
    check("cap_inflight", inflight, 2);
    ret_credits = 1;
    for (int t = 0; t < 200 && in_valid; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("cap_resume", in_valid, 0);
    check("cap_inflight_after", inflight, 2);
    ret_credits = 1000;
    drain();
    // bypass FIFO full with output stalled
    out_mode = 1;
    @(posedge clk); #1;
    base = in_fires;
    fork send_pkt(9, 1); join_none
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_accepted", in_fires - base, 8);
    check("full_fill", byp_fill_level, 8);
    out_mode = 0;
    drain();
    // alternating back-pressure, mixed stream
    out_mode = 2; cli_delay = 2;
    for (int i = 0; i < 10; i++) send_pkt($urandom_range(1, 4), 1'($urandom_range(0, 1)));
    drain();
    // random back-pressure, longer packets
    out_mode = 3;
    for (int i = 0; i < 30; i++) begin
      cli_delay = $urandom_range(0, 5);
      send_pkt($urandom_range(1, 10), 1'($urandom_range(0, 1)));
    end
    drain();
    // reset in the middle of a packet
    out_mode = 1;
    @(posedge clk); #1;
    base = in_fires;
    fork send_pkt(4, 1); join_none
    for (int t = 0; t < 50 && in_fires < base + 1; t++) begin @(negedge clk); #1; end
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ret_ready", ret_ready, 0);
    check("mid_rst_stats", {stats_byp_pkt, stats_proc_pkt}, 0);
    check("mid_rst_out_pkt", stats_out_pkt, 0);
    check("mid_rst_fill", byp_fill_level, 0);
    check("mid_rst_inflight", inflight, 0);
    abort = 1;
    for (int t = 0; t < 50 && in_valid; t++) @(posedge clk);
    exp_q.delete(); exp_b.delete(); cli_q.delete(); cli_t.delete();
    m_byp = 0; m_proc = 0; m_infl = 0; m_fill = 0;
    @(posedge clk); #1;
    rst_n = 1; abort = 0; out_mode = 0; cli_delay = 0;
    send_pkt(3, 0); send_pkt(2, 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
